// File: rtl/fp_pkg.sv
// Shared floating-point FU definitions: rounding-mode encodings, legality check
// and the result record that travels through the completion FIFO.
package fp_pkg;

  localparam int FP_DATA_W = 64;
  localparam int FP_TAG_W  = 16;

  typedef enum logic [2:0] {
    RM_RNE = 3'b000,
    RM_RTZ = 3'b001,
    RM_RDN = 3'b010,
    RM_RUP = 3'b011,
    RM_RMM = 3'b100,
    RM_DYN = 3'b111
  } rm_e;

  // Encodings 101/110 are reserved; 111 is only meaningful before resolution.
  function automatic logic is_legal_rm(input logic [2:0] rm);
    return rm <= RM_RMM;
  endfunction

  typedef struct packed {
    logic [FP_DATA_W-1:0] data;
    logic [FP_TAG_W-1:0]  tag;
    logic                 illegal;
  } fu_result_t;

endpackage

// File: rtl/fu_result_fifo.sv
// Synchronous FIFO of FU results with occupancy count; clear empties it in one cycle.
module fu_result_fifo
  import fp_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clear,
  input  logic                       push,
  input  fu_result_t                 push_data,
  input  logic                       pop,
  output fu_result_t                 head,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  fu_result_t       mem [DEPTH];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !clear;
  assign do_pop  = pop && (count != '0) && !clear;
  assign head    = mem[rd_ptr];

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(do_push && !do_pop && count == CW'(DEPTH)));

endmodule

// File: rtl/fadd_issue_ctrl.sv
// Issue/completion controller for the fixed-latency FP adder: resolves rm, tracks
// in-flight tags and buffers results behind a credit check so none are dropped.
module fadd_issue_ctrl
  import fp_pkg::*;
#(
  parameter int N     = 32,
  parameter int LAT   = 3,
  parameter int TAG_W = 5,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     in_a,
  input  logic [N-1:0]     in_b,
  input  logic             in_sub,
  input  logic [2:0]       in_rm,
  input  logic [TAG_W-1:0] in_tag,
  input  logic [2:0]       fcsr_frm,
  input  logic             flush,
  output logic             fu_valid,
  output logic [N-1:0]     fu_a,
  output logic [N-1:0]     fu_b,
  output logic [2:0]       fu_frm,
  input  logic [N-1:0]     fu_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N-1:0]     out_data,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_illegal,
  output logic             busy
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int IW = $clog2(LAT + 1);
  localparam int SW = ((IW > CW) ? IW : CW) + 1;

  logic             started_q;
  logic [LAT-1:0]   trk_v;
  logic [LAT-1:0]   trk_ill;
  logic [TAG_W-1:0] trk_tag [LAT];
  logic [2:0]       rm;
  logic             legal;
  logic             accept;
  logic [IW-1:0]    inflight;
  logic [SW-1:0]    used;
  logic [CW-1:0]    fifo_count;
  logic             push;
  logic             pop;
  fu_result_t       push_data;
  fu_result_t       head;
  logic             unused_head;

  assign rm     = (in_rm == RM_DYN) ? fcsr_frm : in_rm;
  assign legal  = is_legal_rm(rm);
  assign accept = in_valid && in_ready;

  always_comb begin
    inflight = '0;
    for (int i = 0; i < LAT; i++) inflight = inflight + IW'(trk_v[i]);
  end

  // Every accepted op holds one credit until writeback pops it, so a push can never find the FIFO full.
  assign used     = SW'(inflight) + SW'(fifo_count);
  assign in_ready = started_q && !flush && (used < SW'(DEPTH));

  assign fu_valid = accept && legal;
  assign fu_a     = fu_valid ? in_a : '0;
  assign fu_b     = fu_valid ? {in_b[N-1] ^ in_sub, in_b[N-2:0]} : '0;
  assign fu_frm   = fu_valid ? rm : 3'b000;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) started_q <= 1'b0;
    else        started_q <= 1'b1;
  end

  // Illegal ops ride the tracker too, which keeps completions in accept order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      trk_v   <= '0;
      trk_ill <= '0;
      for (int i = 0; i < LAT; i++) trk_tag[i] <= '0;
    end else begin
      trk_v[0]   <= accept && !flush;
      trk_ill[0] <= !legal;
      trk_tag[0] <= in_tag;
      for (int i = 1; i < LAT; i++) begin
        trk_v[i]   <= trk_v[i-1] && !flush;
        trk_ill[i] <= trk_ill[i-1];
        trk_tag[i] <= trk_tag[i-1];
      end
    end
  end

  always_comb begin
    push_data         = '0;
    push_data.tag     = FP_TAG_W'(trk_tag[LAT-1]);
    push_data.illegal = trk_ill[LAT-1];
    if (!trk_ill[LAT-1]) push_data.data = FP_DATA_W'(fu_out);
  end

  assign push = trk_v[LAT-1];
  assign pop  = out_valid && out_ready;

  fu_result_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (flush),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .head      (head),
    .count     (fifo_count)
  );

  assign out_valid   = fifo_count != '0;
  assign out_data    = out_valid ? head.data[N-1:0] : '0;
  assign out_tag     = out_valid ? head.tag[TAG_W-1:0] : '0;
  assign out_illegal = out_valid && head.illegal;
  assign busy        = (inflight != '0) || (fifo_count != '0);
  assign unused_head = ^head;

endmodule

// File: tb/tb_fadd_issue_ctrl.sv
// Scoreboard bench for fadd_issue_ctrl with a behavioural fixed-latency adder.
module tb_fadd_issue_ctrl;

  localparam int N     = 32;
  localparam int LAT   = 3;
  localparam int TAG_W = 5;
  localparam int DEPTH = 4;

  typedef struct {
    logic [31:0] data;
    logic [4:0]  tag;
    logic        ill;
  } exp_t;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [N-1:0]     in_a;
  logic [N-1:0]     in_b;
  logic             in_sub;
  logic [2:0]       in_rm;
  logic [TAG_W-1:0] in_tag;
  logic [2:0]       fcsr_frm;
  logic             flush;
  logic             fu_valid;
  logic [N-1:0]     fu_a;
  logic [N-1:0]     fu_b;
  logic [2:0]       fu_frm;
  logic [N-1:0]     fu_out;
  logic             out_valid;
  logic             out_ready;
  logic [N-1:0]     out_data;
  logic [TAG_W-1:0] out_tag;
  logic             out_illegal;
  logic             busy;

  int          errors;
  int          checks;
  exp_t        sb_q[$];
  logic [31:0] fu_pipe [LAT];
  logic [31:0] b_tab   [4] = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000};
  logic [31:0] sum_tab [4] = '{32'h40000000, 32'h40400000, 32'h40800000, 32'h40A00000};

  fadd_issue_ctrl #(.N(N), .LAT(LAT), .TAG_W(TAG_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_sub(in_sub), .in_rm(in_rm), .in_tag(in_tag),
    .fcsr_frm(fcsr_frm), .flush(flush), .fu_valid(fu_valid), .fu_a(fu_a),
    .fu_b(fu_b), .fu_frm(fu_frm), .fu_out(fu_out), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_tag(out_tag),
    .out_illegal(out_illegal), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic real sp2r(input logic [31:0] x);
    logic [10:0] e;
    logic [63:0] d;
    if (x[30:0] == 31'd0) d = {x[31], 63'd0};
    else begin
      e = {3'b000, x[30:23]} + 11'd896;
      d = {x[31], e, x[22:0], 29'd0};
    end
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] r2sp(input real r);
    logic [63:0] d;
    logic [10:0] e;
    d = $realtobits(r);
    if (d[62:0] == 63'd0) return {d[63], 31'd0};
    e = d[62:52] - 11'd896;
    return {d[63], e[7:0], d[51:29]};
  endfunction

  // Idle adder slots carry junk so an illegal op's zero data is really produced by the controller.
  always @(posedge clk) begin
    fu_pipe[0] <= fu_valid ? r2sp(sp2r(fu_a) + sp2r(fu_b)) : 32'hDEADBEEF;
    for (int i = 1; i < LAT; i++) fu_pipe[i] <= fu_pipe[i-1];
  end
  assign fu_out = fu_pipe[LAT-1];

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic [31:0] a, input logic [31:0] b,
                               input logic sub, input logic [2:0] rm, input logic [4:0] tag);
    in_valid = v;
    in_a     = a;
    in_b     = b;
    in_sub   = sub;
    in_rm    = rm;
    in_tag   = tag;
    #1;
  endtask

  task automatic idle;
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 3'b000, 5'd0);
  endtask

  task automatic expectOp(input logic [31:0] d, input logic [4:0] t, input logic ill);
    exp_t e;
    e.data = d;
    e.tag  = t;
    e.ill  = ill;
    sb_q.push_back(e);
  endtask

  task automatic monitor;
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && out_valid && out_ready) begin
        checks++;
        if (sb_q.size() == 0) begin
          errors++;
          $display("[TB] FAIL sb_unexpected: got tag %0d data 0x%0h ill %0b, expected no result",
                   out_tag, out_data, out_illegal);
        end else begin
          e = sb_q.pop_front();
          if ({out_data, out_tag, out_illegal} !== {e.data, e.tag, e.ill}) begin
            errors++;
            $display("[TB] FAIL sb_result: got tag %0d data 0x%0h ill %0b, expected tag %0d data 0x%0h ill %0b",
                     out_tag, out_data, out_illegal, e.tag, e.data, e.ill);
          end
        end
      end
    end
  endtask

  task automatic waitIdle(input int budget);
    int n;
    n = 0;
    while (busy && n < budget) begin
      tick();
      n++;
    end
    checkOutput("idle_timeout", 64'(busy), 64'd0);
  endtask

  initial begin
    int acc;
    errors = 0;
    checks = 0;
    rst_n = 1'b0;
    flush = 1'b0;
    out_ready = 1'b1;
    fcsr_frm = 3'b001;
    in_valid = 1'b0; in_a = '0; in_b = '0; in_sub = 1'b0; in_rm = '0; in_tag = '0;
    fork monitor(); join_none

    #2;
    checkOutput("rst_in_ready", 64'(in_ready), 64'd0);
    checkOutput("rst_fu_valid", 64'(fu_valid), 64'd0);
    checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
    checkOutput("rst_busy", 64'(busy), 64'd0);
    checkOutput("rst_out_data", 64'(out_data), 64'd0);
    #20 rst_n = 1'b1;
    #1 checkOutput("ready_before_edge", 64'(in_ready), 64'd0);
    tick();
    checkOutput("ready_after_edge", 64'(in_ready), 64'd1);

    // 1.0 + 2.0, latency LAT+1 to out_valid
    applyStimulus(1'b1, 32'h3F800000, 32'h40000000, 1'b0, 3'b000, 5'd5);
    checkOutput("t1_fu_valid", 64'(fu_valid), 64'd1);
    checkOutput("t1_fu_b", 64'(fu_b), 64'h40000000);
    checkOutput("t1_fu_frm", 64'(fu_frm), 64'd0);
    expectOp(32'h40400000, 5'd5, 1'b0);
    tick();
    idle();
    checkOutput("t1_fu_valid_pulse", 64'(fu_valid), 64'd0);
    checkOutput("t1_busy", 64'(busy), 64'd1);
    tick();
    tick();
    checkOutput("t1_out_valid_c3", 64'(out_valid), 64'd0);
    tick();
    checkOutput("t1_out_valid_c4", 64'(out_valid), 64'd1);
    waitIdle(20);

    // FSUB with dynamic rm resolved from fcsr.frm
    applyStimulus(1'b1, 32'h40400000, 32'h3F800000, 1'b1, 3'b111, 5'd6);
    checkOutput("t2_fu_a", 64'(fu_a), 64'h40400000);
    checkOutput("t2_fu_b", 64'(fu_b), 64'hBF800000);
    checkOutput("t2_fu_frm", 64'(fu_frm), 64'd1);
    expectOp(32'h40000000, 5'd6, 1'b0);
    tick();
    idle();
    waitIdle(20);

    // Illegal rm sandwiched between legal ops, plus a dynamic rm resolving to a reserved value
    applyStimulus(1'b1, 32'h3F800000, 32'h3F800000, 1'b0, 3'b000, 5'd8);
    expectOp(32'h40000000, 5'd8, 1'b0);
    tick();
    applyStimulus(1'b1, 32'h3F800000, 32'h3F800000, 1'b0, 3'b101, 5'd9);
    checkOutput("t3_illegal_fu_valid", 64'(fu_valid), 64'd0);
    checkOutput("t3_illegal_in_ready", 64'(in_ready), 64'd1);
    expectOp(32'h0, 5'd9, 1'b1);
    tick();
    applyStimulus(1'b1, 32'h40000000, 32'h40000000, 1'b0, 3'b000, 5'd10);
    expectOp(32'h40800000, 5'd10, 1'b0);
    tick();
    fcsr_frm = 3'b110;
    applyStimulus(1'b1, 32'h40000000, 32'h40000000, 1'b0, 3'b111, 5'd11);
    checkOutput("t3_dyn_illegal_fu_valid", 64'(fu_valid), 64'd0);
    expectOp(32'h0, 5'd11, 1'b1);
    tick();
    fcsr_frm = 3'b001;
    idle();
    waitIdle(20);

    // Backpressure: only DEPTH ops may be accepted
    out_ready = 1'b0;
    acc = 0;
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, 32'h3F800000, b_tab[acc % 4], 1'b0, 3'b000, 5'(16 + acc));
      if (in_ready) begin
        expectOp(sum_tab[acc % 4], 5'(16 + acc), 1'b0);
        acc++;
      end
      tick();
    end
    idle();
    checkOutput("t4_accepted", 64'(acc), 64'd4);
    tick();
    tick();
    checkOutput("t4_ready_full", 64'(in_ready), 64'd0);
    checkOutput("t4_out_valid", 64'(out_valid), 64'd1);
    out_ready = 1'b1;
    tick();
    checkOutput("t4_ready_reassert", 64'(in_ready), 64'd1);
    waitIdle(20);

    // Flush to zero the pointers, then push and pop together at count=DEPTH-1 as wr_ptr wraps
    flush = 1'b1;
    sb_q.delete();
    #1 checkOutput("t5_flush_ready", 64'(in_ready), 64'd0);
    tick();
    flush = 1'b0;
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 32'h3F800000, b_tab[i], 1'b0, 3'b000, 5'(20 + i));
      expectOp(sum_tab[i], 5'(20 + i), 1'b0);
      tick();
    end
    idle();
    tick();
    tick();
    checkOutput("t5_credit_full", 64'(in_ready), 64'd0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    applyStimulus(1'b1, 32'h3F800000, 32'h3F800000, 1'b0, 3'b000, 5'd24);
    checkOutput("t5_count_stays", 64'(in_ready), 64'd1);
    checkOutput("t5_out_valid", 64'(out_valid), 64'd1);
    expectOp(32'h40000000, 5'd24, 1'b0);
    tick();
    idle();
    repeat (4) tick();
    out_ready = 1'b1;
    waitIdle(20);

    // Flush with two ops buffered and two in flight; the killed ops carry no expectations
    out_ready = 1'b0;
    applyStimulus(1'b1, 32'h3F800000, 32'h3F800000, 1'b0, 3'b000, 5'd25);
    tick();
    applyStimulus(1'b1, 32'h3F800000, 32'h3F800000, 1'b0, 3'b000, 5'd26);
    tick();
    idle();
    tick();
    tick();
    applyStimulus(1'b1, 32'h3F800000, 32'h3F800000, 1'b0, 3'b000, 5'd27);
    tick();
    applyStimulus(1'b1, 32'h3F800000, 32'h3F800000, 1'b0, 3'b000, 5'd28);
    tick();
    flush = 1'b1;
    sb_q.delete();
    applyStimulus(1'b1, 32'h3F800000, 32'h3F800000, 1'b0, 3'b000, 5'd31);
    checkOutput("t6_flush_in_ready", 64'(in_ready), 64'd0);
    checkOutput("t6_flush_fu_valid", 64'(fu_valid), 64'd0);
    tick();
    flush = 1'b0;
    out_ready = 1'b1;
    applyStimulus(1'b1, 32'h3F800000, 32'h3F800000, 1'b0, 3'b000, 5'd1);
    checkOutput("t6_post_out_valid", 64'(out_valid), 64'd0);
    checkOutput("t6_post_busy", 64'(busy), 64'd0);
    checkOutput("t6_post_in_ready", 64'(in_ready), 64'd1);
    expectOp(32'h40000000, 5'd1, 1'b0);
    tick();
    idle();
    tick();
    checkOutput("t6_late_ignored", 64'(out_valid), 64'd0);
    waitIdle(20);

    // Async reset mid-stream drops everything at once
    out_ready = 1'b0;
    applyStimulus(1'b1, 32'h3F800000, 32'h3F800000, 1'b0, 3'b000, 5'd2);
    tick();
    applyStimulus(1'b1, 32'h3F800000, 32'h40000000, 1'b0, 3'b000, 5'd3);
    tick();
    idle();
    repeat (3) tick();
    checkOutput("t7_pre_valid", 64'(out_valid), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("t7_rst_out_valid", 64'(out_valid), 64'd0);
    checkOutput("t7_rst_busy", 64'(busy), 64'd0);
    checkOutput("t7_rst_in_ready", 64'(in_ready), 64'd0);
    checkOutput("t7_rst_out_tag", 64'(out_tag), 64'd0);
    checkOutput("t7_rst_out_data", 64'(out_data), 64'd0);
    sb_q.delete();
    #10 rst_n = 1'b1;
    out_ready = 1'b1;
    repeat (6) tick();
    checkOutput("t7_post_busy", 64'(busy), 64'd0);
    applyStimulus(1'b1, 32'h3F800000, 32'h40000000, 1'b0, 3'b000, 5'd3);
    expectOp(32'h40400000, 5'd3, 1'b0);
    tick();
    idle();
    waitIdle(20);
    tick();

    checkOutput("sb_drained", 64'(sb_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
